mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters (name, default, meaning): AW, 8, address width; DW, 16, data width; TMO, 15, max wait cycles for mem_ack (1..255).
REQ-002 Ports (name, direction, width, meaning):
clk  in  1  single clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
if_req  in  1  instruction-fetch read request; held high until if_done
if_addr  in  AW  fetch address
if_done  out  1  one-cycle completion pulse to fetch requester
if_rdata  out  DW  fetched word; valid while if_done=1
ls_req  in  1  load/store request; held high until ls_done
ls_we  in  1  1=store, 0=load
ls_addr  in  AW  load/store address
ls_wdata  in  DW  store data
ls_done  out  1  one-cycle completion pulse to load/store requester
ls_rdata  out  DW  load data; valid while ls_done=1
err  out  1  high with a done pulse when that access timed out
mem_req  out  1  memory access request
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid with mem_ack
mem_ack  in  1  memory completion, one or more cycles after mem_req
busy  out  1  high while an access is outstanding
REQ-003 Clock is clk only; reset is rst_n, asynchronous assert, active-low; no other clock or reset.

Function
REQ-004 FSM states: IDLE, ACC_IF, ACC_LS, DONE; all outputs registered.
REQ-005 IDLE: no eligible request -> stay; exactly one eligible -> grant it; both eligible -> grant the one NOT granted last (round-robin via last_gnt bit).
REQ-006 Grant in cycle N (IDLE sampled req) -> state ACC_xx at N+1 with mem_req=1 and mem_addr/mem_we/mem_wdata driven from values latched at cycle N; for fetch mem_we=0, mem_wdata=0.
REQ-007 Requester inputs changing after the grant shall not affect the access in flight.
REQ-008 ACC_xx: mem_req, mem_addr, mem_we, mem_wdata stable until mem_ack sampled high; wait counter increments each ACC cycle, starting at 0 on entry.
REQ-009 mem_ack sampled high in cycle M -> at M+1: state DONE, mem_req=0, matching done=1, matching rdata=mem_rdata captured at M (0 for stores), err=0.
REQ-010 Counter reaching TMO with mem_ack low -> next cycle: state DONE, mem_req=0, matching done=1, rdata=0, err=1.
REQ-011 mem_ack and counter==TMO in same cycle: ack wins, err=0.
REQ-012 DONE lasts exactly one cycle, then IDLE; done/err deassert after it; last_gnt updated to the completed requester.
REQ-013 Holdoff: the requester completed in the DONE cycle is ineligible in the following IDLE cycle; the other requester is eligible; minimum spacing between grants is 3 cycles (IDLE, ACC, DONE).
REQ-014 mem_ack while state is IDLE or DONE shall be ignored.
REQ-015 busy=1 in ACC_IF, ACC_LS, DONE; 0 in IDLE.
REQ-016 if_done and ls_done never high in the same cycle; at most one mem_req access outstanding.
REQ-017 Widths exact; counter width ceil(log2(TMO+1)), saturating, no wrap.

Reset
REQ-018 rst_n low -> immediately (no clock edge): state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_done=0, ls_done=0, if_rdata=0, ls_rdata=0, err=0, busy=0, counter=0, last_gnt=LS (so fetch wins the first tie).
REQ-019 Reset mid-access aborts it with no done pulse; after rst_n rises, first grant no earlier than first clk edge with rst_n high.

Verification
REQ-020 Fetch alone: if_req=1, if_addr=0x10, mem_ack 2 cycles after mem_req with mem_rdata=0xBEEF -> mem_addr=0x10, mem_we=0, if_done one cycle, if_rdata=0xBEEF, err=0.
REQ-021 Tie after reset: if_req and ls_req rise same cycle -> fetch granted first, load/store granted in the IDLE cycle after fetch DONE; next tie goes to LS.
REQ-022 Store: ls_we=1, ls_addr=0x42, ls_wdata=0x1234, ls_wdata changed after grant -> mem_wdata stays 0x1234, ls_done pulses, ls_rdata=0.
REQ-023 Timeout: TMO=15, mem_ack never asserted -> mem_req high exactly 16 cycles, then done=1 with err=1, rdata=0; ack on the 16th cycle -> err=0.
REQ-024 Reset mid-access: rst_n low during ACC_LS -> mem_req=0 and busy=0 without clock edge, no ls_done; stray mem_ack after reset ignored.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: instruction fetch and load/store share one
// memory port, granted round-robin, with a per-access timeout and error flag.
module mem_arbiter #(
  parameter int AW  = 8,
  parameter int DW  = 16,
  parameter int TMO = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_done,
  output logic [DW-1:0] if_rdata,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [AW-1:0] ls_addr,
  input  logic [DW-1:0] ls_wdata,
  output logic          ls_done,
  output logic [DW-1:0] ls_rdata,
  output logic          err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          busy
);

  localparam int CW = $clog2(TMO + 1);
  localparam logic [CW-1:0] TMO_C = CW'(TMO);

  typedef enum logic [1:0] {IDLE, ACC_IF, ACC_LS, DONE} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          last_gnt, last_gnt_n;
  logic          hold, hold_n;
  logic          mem_req_n, mem_we_n;
  logic [AW-1:0] mem_addr_n;
  logic [DW-1:0] mem_wdata_n;
  logic          if_done_n, ls_done_n, err_n, busy_n;
  logic [DW-1:0] if_rdata_n, ls_rdata_n;
  logic          if_elig, ls_elig, grant_ls;

  // last_gnt: 1 = load/store completed most recently. hold is high only in the
  // IDLE cycle right after DONE, locking out the requester that just finished.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    last_gnt_n  = last_gnt;
    hold_n      = 1'b0;
    mem_req_n   = mem_req;
    mem_we_n    = mem_we;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    if_done_n   = 1'b0;
    ls_done_n   = 1'b0;
    if_rdata_n  = '0;
    ls_rdata_n  = '0;
    err_n       = 1'b0;
    if_elig     = if_req && !(hold && !last_gnt);
    ls_elig     = ls_req && !(hold && last_gnt);
    grant_ls    = 1'b0;

    case (state)
      IDLE: begin
        grant_ls = ls_elig && (!if_elig || !last_gnt);
        if (if_elig || ls_elig) begin
          cnt_n     = '0;
          mem_req_n = 1'b1;
          if (grant_ls) begin
            state_n     = ACC_LS;
            mem_we_n    = ls_we;
            mem_addr_n  = ls_addr;
            mem_wdata_n = ls_wdata;
          end else begin
            state_n     = ACC_IF;
            mem_we_n    = 1'b0;
            mem_addr_n  = if_addr;
            mem_wdata_n = '0;
          end
        end
      end
      ACC_IF, ACC_LS: begin
        if (mem_ack || cnt == TMO_C) begin
          state_n   = DONE;
          mem_req_n = 1'b0;
          mem_we_n  = 1'b0;
          if_done_n = (state == ACC_IF);
          ls_done_n = (state == ACC_LS);
          err_n     = !mem_ack;
          if (mem_ack && state == ACC_IF) if_rdata_n = mem_rdata;
          if (mem_ack && state == ACC_LS && !mem_we) ls_rdata_n = mem_rdata;
        end else begin
          // reaching TMO always ends the access, so the counter cannot wrap
          cnt_n = cnt + 1'b1;
        end
      end
      DONE: begin
        state_n    = IDLE;
        last_gnt_n = ls_done;
        hold_n     = 1'b1;
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      last_gnt  <= 1'b1;
      hold      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_done   <= 1'b0;
      ls_done   <= 1'b0;
      if_rdata  <= '0;
      ls_rdata  <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      last_gnt  <= last_gnt_n;
      hold      <= hold_n;
      mem_req   <= mem_req_n;
      mem_we    <= mem_we_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      if_done   <= if_done_n;
      ls_done   <= ls_done_n;
      if_rdata  <= if_rdata_n;
      ls_rdata  <= ls_rdata_n;
      err       <= err_n;
      busy      <= busy_n;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a small memory responder plus a scoreboard
// of expected completions, checked with immediate assertions.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, ls_req, ls_we, mem_ack;
  logic [7:0]  if_addr, ls_addr;
  logic [15:0] ls_wdata, mem_rdata;
  logic        if_done, ls_done, err, mem_req, mem_we, busy;
  logic [15:0] if_rdata, ls_rdata, mem_wdata;
  logic [7:0]  mem_addr;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit          is_ls;
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];

  mem_arbiter #(.AW(8), .DW(16), .TMO(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_done(ls_done), .ls_rdata(ls_rdata), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Raise a request and record the completion it should produce.
  task automatic applyStimulus(input bit is_ls, input logic we, input logic [7:0] addr,
                               input logic [15:0] wdata, input logic [15:0] exp_rdata, input logic exp_err);
    exp_t e;
    if (is_ls) begin
      ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    e.is_ls = is_ls; e.rdata = exp_rdata; e.err = exp_err;
    sb.push_back(e);
  endtask

  task automatic check_done(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    checkOutput({tag, "_if_done"}, if_done, !e.is_ls);
    checkOutput({tag, "_ls_done"}, ls_done, e.is_ls);
    checkOutput({tag, "_err"}, err, e.err);
    checkOutput({tag, "_rdata"}, e.is_ls ? ls_rdata : if_rdata, e.rdata);
    checkOutput({tag, "_req_low"}, mem_req, 1'b0);
    checkOutput({tag, "_busy_done"}, busy, 1'b1);
    if (e.is_ls) ls_req = 1'b0; else if_req = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_done_clear"}, {if_done, ls_done, err}, 3'b000);
    checkOutput({tag, "_idle_busy"}, busy, 1'b0);
  endtask

  // Memory responder for one access: delay<0 means never acknowledge.
  task automatic serve(input string tag, input bit is_ls, input int exp_wait, input int delay,
                       input logic [15:0] rdata, input logic [7:0] exp_addr,
                       input logic exp_we, input logic [15:0] exp_wdata);
    int waited = 0;
    int n = 0;
    while (!mem_req && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    checkOutput({tag, "_grant_wait"}, waited, exp_wait);
    if (!mem_req) return;
    checkOutput({tag, "_addr"}, mem_addr, exp_addr);
    checkOutput({tag, "_we"}, mem_we, exp_we);
    checkOutput({tag, "_wdata"}, mem_wdata, exp_wdata);
    checkOutput({tag, "_busy"}, busy, 1'b1);
    if (is_ls) begin
      ls_addr = ~ls_addr; ls_wdata = ~ls_wdata; ls_we = ~ls_we;
    end else begin
      if_addr = ~if_addr;
    end
    if (delay >= 0) begin
      repeat (delay) @(negedge clk);
      checkOutput({tag, "_hold_req"}, mem_req, 1'b1);
      checkOutput({tag, "_hold_addr"}, mem_addr, exp_addr);
      checkOutput({tag, "_hold_we"}, mem_we, exp_we);
      checkOutput({tag, "_hold_wdata"}, mem_wdata, exp_wdata);
      mem_rdata = rdata;
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      mem_rdata = 16'hDEAD;
    end else begin
      while (mem_req && n < 40) begin
        @(negedge clk);
        n++;
      end
      checkOutput({tag, "_req_cycles"}, n, 16);
    end
    check_done(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0; mem_ack = 1'b0;
    if_addr = '0; ls_addr = '0; ls_wdata = '0; mem_rdata = '0;
    #2;
    checkOutput("rst_mem", {mem_req, mem_we, busy, err, if_done, ls_done}, 6'b0);
    checkOutput("rst_addr", mem_addr, 8'h00);
    checkOutput("rst_wdata", mem_wdata, 16'h0000);
    checkOutput("rst_rdata", {if_rdata, ls_rdata}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // first tie after reset goes to fetch, then load/store
    applyStimulus(1'b0, 1'b0, 8'h20, 16'h0000, 16'h1111, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h30, 16'h0000, 16'h2222, 1'b0);
    serve("tie1_if", 1'b0, 1, 1, 16'h1111, 8'h20, 1'b0, 16'h0000);
    serve("tie1_ls", 1'b1, 1, 0, 16'h2222, 8'h30, 1'b0, 16'h0000);

    applyStimulus(1'b0, 1'b0, 8'h10, 16'h0000, 16'hBEEF, 1'b0);
    serve("fetch", 1'b0, 1, 2, 16'hBEEF, 8'h10, 1'b0, 16'h0000);
    @(negedge clk);

    // fetch completed last, so this tie goes to load/store (a store)
    applyStimulus(1'b1, 1'b1, 8'h42, 16'h1234, 16'h0000, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h11, 16'h0000, 16'h3333, 1'b0);
    serve("store", 1'b1, 1, 1, 16'h5555, 8'h42, 1'b1, 16'h1234);
    serve("tie2_if", 1'b0, 1, 0, 16'h3333, 8'h11, 1'b0, 16'h0000);

    applyStimulus(1'b0, 1'b0, 8'h12, 16'h0000, 16'h4444, 1'b0);
    serve("holdoff_if", 1'b0, 2, 0, 16'h4444, 8'h12, 1'b0, 16'h0000);

    applyStimulus(1'b1, 1'b0, 8'h50, 16'h0000, 16'h0000, 1'b1);
    serve("timeout", 1'b1, 1, -1, 16'h0000, 8'h50, 1'b0, 16'h0000);

    applyStimulus(1'b1, 1'b0, 8'h51, 16'h0000, 16'h7777, 1'b0);
    serve("ack_at_tmo", 1'b1, 2, 15, 16'h7777, 8'h51, 1'b0, 16'h0000);

    mem_ack = 1'b1; mem_rdata = 16'h9999;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("idle_ack", {mem_req, if_done, ls_done, busy, err}, 5'b0);
    end
    mem_ack = 1'b0;

    // reset in the middle of a load aborts it without a done pulse
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 8'h60;
    begin
      int w = 0;
      while (!mem_req && w < 40) begin
        @(negedge clk);
        w++;
      end
      checkOutput("rst_mid_grant", w, 1);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_req", {mem_req, busy}, 2'b00);
    checkOutput("rst_mid_done", {if_done, ls_done, err}, 3'b000);
    checkOutput("rst_mid_addr", mem_addr, 8'h00);
    ls_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 16'h8888;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("rst_stray_ack", {mem_req, if_done, ls_done, busy, err}, 5'b0);
    end
    mem_ack = 1'b0;

    applyStimulus(1'b0, 1'b0, 8'h77, 16'h0000, 16'hAAAA, 1'b0);
    serve("post_rst", 1'b0, 1, 3, 16'hAAAA, 8'h77, 1'b0, 16'h0000);

    checkOutput("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
